// File: rtl/idli_sqi_seq_m.sv
// idli_sqi_seq_m: SQI memory sequencer driving CS, command, address, dummy and data phases.
// Define IDLI_SQI_ADDR_TRACK_EN to enable the o_sqi_cur_addr next-word address counter.
package idli_sqi_pkg;
    typedef enum logic {SQI_MODE_OUT, SQI_MODE_IN} sqi_mode_t;
endpackage

module idli_sqi_seq_m
    import idli_sqi_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DUMMY_CYC   = 2,
    parameter int CS_HIGH_CYC = 2
) (
    input  logic              i_sqi_gck,
    input  logic              i_sqi_rst_n,
    input  logic              i_sqi_req_vld,
    output logic              o_sqi_req_rdy,
    input  logic              i_sqi_req_rd,
    input  logic [ADDR_W-1:0] i_sqi_req_addr,
    input  logic [DATA_W-1:0] i_sqi_req_wr_data,
    input  logic              i_sqi_stop,
    output logic              o_sqi_rd_vld,
    output logic [DATA_W-1:0] o_sqi_rd_data,
    output logic              o_sqi_wr_done,
    output logic              o_sqi_busy,
    output logic [ADDR_W-1:0] o_sqi_cur_addr,
    output logic              o_sqi_sck,
    output logic              o_sqi_cs,
    output sqi_mode_t         o_sqi_mode,
    output logic [3:0]        o_sqi_data,
    input  logic [3:0]        i_sqi_data
);
    localparam int N = DATA_W / 4;
    localparam int A = ADDR_W / 4;

    typedef enum logic [2:0] {IDLE, CSH, CMD, ADDR, DUMMY, DATA} state_t;

    state_t            state, state_nxt;
    logic [7:0]        cnt, lim;
    logic              rd_q, last, word_end, acc;
    logic [ADDR_W-1:0] addr_sh;
    logic [DATA_W-1:0] sh;

    always_comb begin
        lim = state == CSH   ? 8'(CS_HIGH_CYC - 1) :
              state == CMD   ? 8'd1 :
              state == ADDR  ? 8'(A - 1) :
              state == DUMMY ? 8'(DUMMY_CYC - 1) :
              state == DATA  ? 8'(N - 1) : 8'd0;
        last = cnt == lim;
        word_end = state == DATA && last;
        o_sqi_req_rdy = state == IDLE || (word_end && rd_q);
        acc = i_sqi_req_vld && o_sqi_req_rdy;
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = acc ? CSH : IDLE;
            CSH:     state_nxt = last ? CMD : CSH;
            CMD:     state_nxt = last ? ADDR : CMD;
            ADDR:    state_nxt = !last ? ADDR : rd_q ? DUMMY : DATA;
            DUMMY:   state_nxt = last ? DATA : DUMMY;
            DATA:    state_nxt = !last ? DATA : !rd_q ? IDLE : acc ? CSH : i_sqi_stop ? IDLE : DATA;
            default: state_nxt = IDLE;
        endcase
    end

    assign o_sqi_cs   = state == IDLE || state == CSH;
    assign o_sqi_sck  = o_sqi_cs ? 1'b0 : i_sqi_gck;
    assign o_sqi_busy = state != IDLE;
    assign o_sqi_mode = (state == DATA && rd_q) ? SQI_MODE_IN : SQI_MODE_OUT;
    assign o_sqi_data = state == CMD ? (cnt[0] ? {3'b001, rd_q} : 4'h0) :
                        state == ADDR ? addr_sh[ADDR_W-1 -: 4] :
                        (state == DATA && !rd_q) ? sh[DATA_W-1 -: 4] : 4'h0;

    // Address and write data leave MS nibble first by shifting left; read data shifts in at the bottom.
    always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
        if (!i_sqi_rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            rd_q          <= 1'b0;
            addr_sh       <= '0;
            sh            <= '0;
            o_sqi_rd_data <= '0;
            o_sqi_rd_vld  <= 1'b0;
            o_sqi_wr_done <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= last ? '0 : cnt + 8'd1;
            o_sqi_rd_vld  <= word_end && rd_q;
            o_sqi_wr_done <= word_end && !rd_q;
            if (word_end && rd_q)
                o_sqi_rd_data <= DATA_W'({sh, i_sqi_data});
            if (acc) begin
                rd_q    <= i_sqi_req_rd;
                addr_sh <= i_sqi_req_addr;
                sh      <= i_sqi_req_wr_data;
            end else begin
                if (state == ADDR)
                    addr_sh <= addr_sh << 4;
                if (state == DATA)
                    sh <= rd_q ? DATA_W'({sh, i_sqi_data}) : sh << 4;
            end
        end
    end

`ifdef IDLI_SQI_ADDR_TRACK_EN
    // A redirect accepted on a word boundary overrides that word's increment.
    always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
        if (!i_sqi_rst_n)
            o_sqi_cur_addr <= '0;
        else if (acc)
            o_sqi_cur_addr <= i_sqi_req_addr;
        else if (word_end)
            o_sqi_cur_addr <= o_sqi_cur_addr + ADDR_W'(DATA_W / 8);
    end
`else
    assign o_sqi_cur_addr = '0;
`endif
endmodule

// File: doc/idli_sqi_seq_m.md
Name: idli_sqi_seq_m

Overview:
- Parametrised SQI memory sequencer.
- Owns the full SQI pin protocol: CS pulse, command, address, dummy, data.
- Serves a request/ready front end from the core. Reads stream sequential words until stopped or redirected; writes are single-word.
- Generalises the fixed 16b/4-cycle control sequencing to configurable address/data widths, dummy length and CS-high time, and adds redirect and stop handling.

Parameters:
- DATA_W, 16, word width in bits; multiple of 4, at least 4. N = DATA_W/4 nibble cycles per word.
- ADDR_W, 16, address width in bits; multiple of 4. A = ADDR_W/4 nibble cycles.
- DUMMY_CYC, 2, clocked dummy cycles on reads, at least 1.
- CS_HIGH_CYC, 2, cycles CS is held high before each command, at least 1.

Ports:
- i_sqi_gck  in  1  core clock
- i_sqi_rst_n  in  1  reset, asynchronous, active-low
- i_sqi_req_vld  in  1  request valid
- o_sqi_req_rdy  out  1  request ready
- i_sqi_req_rd  in  1  1 = read, 0 = write
- i_sqi_req_addr  in  ADDR_W  start byte address
- i_sqi_req_wr_data  in  DATA_W  write word
- i_sqi_stop  in  1  end read stream at next word boundary
- o_sqi_rd_vld  out  1  read word valid, one-cycle pulse
- o_sqi_rd_data  out  DATA_W  read word
- o_sqi_wr_done  out  1  write complete, one-cycle pulse
- o_sqi_busy  out  1  state != IDLE
- o_sqi_cur_addr  out  ADDR_W  address of next word (optional feature)
- o_sqi_sck  out  1  memory clock
- o_sqi_cs  out  1  chip select, active-high deselect
- o_sqi_mode  out  sqi_mode_t  pin direction
- o_sqi_data  out  4  nibble to memory
- i_sqi_data  in  4  nibble from memory

Behaviour:
- Reset: one clock, async active-low reset.
  - State goes to IDLE; counters go to 0.
  - Outputs in reset: o_sqi_cs=1, o_sqi_req_rdy=1, o_sqi_rd_vld=0, o_sqi_wr_done=0, o_sqi_busy=0, o_sqi_mode=SQI_MODE_OUT, o_sqi_data=0, o_sqi_rd_data=0, o_sqi_cur_addr=0.
  - Reset mid-transaction aborts immediately: CS high, no rd_vld or wr_done pulse.
- Accept: a request is accepted on a clock edge where i_sqi_req_vld and o_sqi_req_rdy are both high. Address, rd flag and wr_data are latched on that edge.
- State sequence: IDLE -> CSH (CS_HIGH_CYC cycles) -> CMD (2) -> ADDR (A) -> DUMMY (DUMMY_CYC, reads only) -> DATA (N).
  - Writes skip DUMMY.
  - A per-state cycle counter drives the transitions.
- Pin outputs:
  - o_sqi_cs: 1 in IDLE and CSH, 0 otherwise.
  - o_sqi_sck: i_sqi_gck when CS=0, else 0.
  - o_sqi_data in CMD: cycle 0 = 4'h0; cycle 1 = {3'b001, rd}, i.e. 0x03 read, 0x02 write.
  - o_sqi_data in ADDR: address MS nibble first.
  - o_sqi_data in write DATA: wr_data MS nibble first.
  - o_sqi_data is 0 in all other states.
  - o_sqi_mode: SQI_MODE_IN only in read DATA, SQI_MODE_OUT otherwise.
- Read DATA:
  - i_sqi_data is sampled on each posedge and shifted in, MS nibble first.
  - On the edge closing nibble N-1: o_sqi_rd_data is updated and o_sqi_rd_vld pulses for one cycle.
  - Streaming continues with the nibble counter wrapped, CS held low; the memory auto-increments.
- Read latency: the rd_vld rising edge comes CS_HIGH_CYC+2+A+DUMMY_CYC+N edges after the accept edge. Defaults: 14.
- Word boundary (read DATA, last nibble cycle): o_sqi_req_rdy=1 in this cycle only.
  - New request accepted: the current word still completes with rd_vld; next state is CSH (redirect).
  - Else i_sqi_stop=1: next state is IDLE.
  - Request and stop together: the request wins.
  - Neither: stay in DATA.
  - i_sqi_stop outside the boundary cycle is ignored; it is not sticky.
- Write: after the last DATA nibble, o_sqi_wr_done pulses on the same edge as the transition to IDLE.
- o_sqi_req_rdy: 1 in IDLE; 1 in the read DATA boundary cycle; 0 everywhere else, including write DATA.

Optional Feature:
- Macro: IDLI_SQI_ADDR_TRACK_EN.
- Defined:
  - o_sqi_cur_addr loads the request address on accept.
  - It increments by DATA_W/8 on every rd_vld or wr_done pulse, wrapping modulo 2^ADDR_W.
- Undefined: o_sqi_cur_addr is tied to 0 and there is no counter flop.

Test Plan:
- Reset, then read at addr 0x1234 (defaults), memory returns 0xBEEF:
  - ADDR nibbles 1,2,3,4 and CMD 0x0,0x3 on the pins.
  - rd_vld on edge 14 with data 0xBEEF; cur_addr=0x1236.
- Write 0xA5C3 to addr 0x0010: CMD 0x0,0x2; no DUMMY; data nibbles A,5,C,3; wr_done on edge 12; busy drops.
- Stream 3 words, then stop at the third boundary: three rd_vld pulses 4 cycles apart; CS rises after the third.
- Redirect to 0x2000 plus stop together at a boundary: the current word is delivered, CSH is entered (not IDLE), and the new ADDR phase sends 2,0,0,0.
- Assert reset mid-ADDR: CS=1 and sck=0 immediately; no pulses; a fresh read afterwards completes normally.
- Compile with DATA_W=32, ADDR_W=24, DUMMY_CYC=4: rd_vld on edge 2+2+6+4+8=22; cur_addr advances by 4.
